// File: rtl/reorder_buffer_pkg.sv
// Shared configuration for the reorder buffer: bus widths, depth, the opcode
// map that dispatch and the ROB both decode, and the ROB entry layout.
package reorder_buffer_pkg;

  localparam int NICK_BUS_W = 5;   // rename tag width (tag = index + 1)
  localparam int DATA_BUS_W = 32;  // data / pc width
  localparam int NAME_BUS_W = 5;   // architectural register name width
  localparam int OP_BUS_W   = 6;   // internal opcode width
  localparam int ROB_DEPTH  = 16;  // entries, power of two

  // Internal opcode encoding produced by the decoder.
  localparam logic [OP_BUS_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_BUS_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_BUS_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_BUS_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_BUS_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_BUS_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_BUS_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_BUS_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_BUS_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_BUS_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_BUS_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_BUS_W-1:0] OP_LB    = 6'd11;
  localparam logic [OP_BUS_W-1:0] OP_LH    = 6'd12;
  localparam logic [OP_BUS_W-1:0] OP_LW    = 6'd13;
  localparam logic [OP_BUS_W-1:0] OP_LBU   = 6'd14;
  localparam logic [OP_BUS_W-1:0] OP_LHU   = 6'd15;
  localparam logic [OP_BUS_W-1:0] OP_SB    = 6'd16;
  localparam logic [OP_BUS_W-1:0] OP_SH    = 6'd17;
  localparam logic [OP_BUS_W-1:0] OP_SW    = 6'd18;
  localparam logic [OP_BUS_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_BUS_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_BUS_W-1:0] OP_XORI  = 6'd21;
  localparam logic [OP_BUS_W-1:0] OP_ORI   = 6'd22;
  localparam logic [OP_BUS_W-1:0] OP_ANDI  = 6'd23;
  localparam logic [OP_BUS_W-1:0] OP_ADD   = 6'd24;
  localparam logic [OP_BUS_W-1:0] OP_SUB   = 6'd25;

  // Retirement class: decides what commit does with the entry.
  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,  // writes rd (also loads, LUI, JAL)
    CLS_STORE  = 2'd1,  // releases a store to the LSB
    CLS_BRANCH = 2'd2,  // conditional branch, checks prediction
    CLS_JALR   = 2'd3   // writes rd and always redirects
  } op_class_e;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    logic [NAME_BUS_W-1:0] rd;
    op_class_e             cls;
    logic [DATA_BUS_W-1:0] dt;
    logic                  pd;
    logic                  jump;
    logic [DATA_BUS_W-1:0] target;
    logic [DATA_BUS_W-1:0] pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_op_class.sv
// Combinational opcode-to-retirement-class decoder, shared with dispatch.
module rob_op_class
  import reorder_buffer_pkg::*;
(
  input  logic [OP_BUS_W-1:0] op_i,
  output op_class_e           cls_o
);

  // Map each opcode onto what commit must do with it.
  always_comb begin
    cls_o = CLS_ALU;
    case (op_i)
      OP_JALR:                                   cls_o = CLS_JALR;
      OP_BEQ, OP_BNE, OP_BLT,
      OP_BGE, OP_BLTU, OP_BGEU:                  cls_o = CLS_BRANCH;
      OP_SB, OP_SH, OP_SW:                       cls_o = CLS_STORE;
      default:                                   cls_o = CLS_ALU;
    endcase
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue for the Tomasulo core. Allocates rename tags at
// dispatch, collects ALU/LSB broadcast results, retires one entry per cycle
// to the regfile / LSB, and flushes the pipeline on a mispredict.
//
// Handshake semantics: dispatch presents iDP_en with its fields; the entry is
// taken on the rising edge where iDP_en & !oDP_full & !oclr & rdy, and the tag
// offered on oDP_nick in that cycle is the one assigned. Result buses are
// fire-and-forget (en qualifies nick/dt in the same cycle, no back-pressure).
// Commit outputs are single-cycle registered pulses; their data fields hold
// their last committed value between pulses.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = ROB_DEPTH,
  parameter int NICK_W   = NICK_BUS_W,
  parameter int OP_W     = OP_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  // dispatch
  input  logic              iDP_en,
  input  logic [4:0]        iDP_rd_regnm,
  input  logic [OP_W-1:0]   iDP_op,
  input  logic [31:0]       iDP_pc,
  input  logic              iDP_pd,
  output logic [NICK_W-1:0] oDP_nick,
  output logic              oDP_full,
  input  logic [NICK_W-1:0] iDP_rs1_nick,
  input  logic [NICK_W-1:0] iDP_rs2_nick,
  output logic              oDP_rs1_rdy,
  output logic              oDP_rs2_rdy,
  output logic [31:0]       oDP_rs1_dt,
  output logic [31:0]       oDP_rs2_dt,
  // rename write to regfile
  output logic              oRF_nick_en,
  output logic [4:0]        oRF_nick_regnm,
  output logic [NICK_W-1:0] oRF_nick,
  // result buses
  input  logic              iALU_en,
  input  logic [NICK_W-1:0] iALU_nick,
  input  logic [31:0]       iALU_dt,
  input  logic              iALU_jump,
  input  logic [31:0]       iALU_target,
  input  logic              iLSB_en,
  input  logic [NICK_W-1:0] iLSB_nick,
  input  logic [31:0]       iLSB_dt,
  // commit
  output logic              oRF_en,
  output logic [4:0]        oRF_rd_regnm,
  output logic [31:0]       oRF_rd_dt,
  output logic [NICK_W-1:0] oRF_rd_nick,
  output logic              oLSB_commit_en,
  output logic [NICK_W-1:0] oLSB_commit_nick,
  output logic              oclr,
  output logic [31:0]       oIF_pc
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  // Tag for a given slot: slot index + 1, so tag 0 stays free for "no rename".
  function automatic logic [NICK_W-1:0] nick_of(input logic [IDX_W-1:0] idx);
    nick_of = {{(NICK_W-IDX_W){1'b0}}, idx} + NICK_W'(1);
  endfunction

  // Slot addressed by a non-zero tag; tag ROB_SIZE wraps cleanly to the last slot.
  function automatic logic [IDX_W-1:0] idx_of(input logic [NICK_W-1:0] nick);
    idx_of = nick[IDX_W-1:0] - IDX_W'(1);
  endfunction

  rob_entry_t        entries_q [ROB_SIZE];
  rob_entry_t        entries_d [ROB_SIZE];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              rf_en_q, rf_en_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [31:0]       rf_dt_q, rf_dt_d;
  logic [NICK_W-1:0] rf_nick_q, rf_nick_d;
  logic              lsb_en_q, lsb_en_d;
  logic [NICK_W-1:0] lsb_nick_q, lsb_nick_d;
  logic              clr_q, clr_d;
  logic [31:0]       if_pc_q, if_pc_d;

  op_class_e         dp_cls;
  rob_entry_t        head_e;
  logic [IDX_W-1:0]  alu_idx, lsb_idx;
  logic              alu_wb, lsb_wb;
  logic              alloc, commit, mispredict, flush;

  rob_op_class u_op_class (
    .op_i  (iDP_op),
    .cls_o (dp_cls)
  );

  assign head_e   = entries_q[head_q];
  assign alu_idx  = idx_of(iALU_nick);
  assign lsb_idx  = idx_of(iLSB_nick);

  // Conservative full: a commit in the same cycle does not free a slot early.
  assign oDP_full = (count_q == CNT_W'(ROB_SIZE));
  assign oDP_nick = nick_of(tail_q);

  assign alloc  = iDP_en && !oDP_full && !clr_q && rdy;
  assign alu_wb = rdy && iALU_en && (iALU_nick != '0) && entries_q[alu_idx].busy;
  assign lsb_wb = rdy && iLSB_en && (iLSB_nick != '0) && entries_q[lsb_idx].busy;

  assign commit     = rdy && head_e.busy && head_e.ready;
  assign mispredict = (head_e.cls == CLS_JALR) ||
                      ((head_e.cls == CLS_BRANCH) && (head_e.jump != head_e.pd));
  assign flush      = commit && mispredict;

  // Rename write: only instructions that produce a real register value.
  assign oRF_nick_en    = alloc && (dp_cls != CLS_STORE) && (dp_cls != CLS_BRANCH) &&
                          (iDP_rd_regnm != 5'd0);
  assign oRF_nick_regnm = iDP_rd_regnm;
  assign oRF_nick       = oDP_nick;

  // Operand lookup: a live bus result wins over the stored value, ALU first.
  always_comb begin
    oDP_rs1_rdy = 1'b0;
    oDP_rs1_dt  = '0;
    if (iDP_rs1_nick != '0) begin
      if (iALU_en && (iALU_nick == iDP_rs1_nick)) begin
        oDP_rs1_rdy = 1'b1;
        oDP_rs1_dt  = iALU_dt;
      end else if (iLSB_en && (iLSB_nick == iDP_rs1_nick)) begin
        oDP_rs1_rdy = 1'b1;
        oDP_rs1_dt  = iLSB_dt;
      end else if (entries_q[idx_of(iDP_rs1_nick)].ready) begin
        oDP_rs1_rdy = 1'b1;
        oDP_rs1_dt  = entries_q[idx_of(iDP_rs1_nick)].dt;
      end
    end
  end

  // Same lookup for the second operand.
  always_comb begin
    oDP_rs2_rdy = 1'b0;
    oDP_rs2_dt  = '0;
    if (iDP_rs2_nick != '0) begin
      if (iALU_en && (iALU_nick == iDP_rs2_nick)) begin
        oDP_rs2_rdy = 1'b1;
        oDP_rs2_dt  = iALU_dt;
      end else if (iLSB_en && (iLSB_nick == iDP_rs2_nick)) begin
        oDP_rs2_rdy = 1'b1;
        oDP_rs2_dt  = iLSB_dt;
      end else if (entries_q[idx_of(iDP_rs2_nick)].ready) begin
        oDP_rs2_rdy = 1'b1;
        oDP_rs2_dt  = entries_q[idx_of(iDP_rs2_nick)].dt;
      end
    end
  end

  // Entry next-state: writebacks, retire, allocate, then a flush drops everything.
  always_comb begin
    entries_d = entries_q;
    if (alu_wb) begin
      entries_d[alu_idx].ready  = 1'b1;
      entries_d[alu_idx].dt     = iALU_dt;
      entries_d[alu_idx].jump   = iALU_jump;
      entries_d[alu_idx].target = iALU_target;
    end
    if (lsb_wb) begin
      entries_d[lsb_idx].ready = 1'b1;
      entries_d[lsb_idx].dt    = iLSB_dt;
    end
    if (commit) begin
      entries_d[head_q].busy = 1'b0;
    end
    if (alloc) begin
      entries_d[tail_q].busy   = 1'b1;
      entries_d[tail_q].ready  = (dp_cls == CLS_STORE);
      entries_d[tail_q].rd     = iDP_rd_regnm;
      entries_d[tail_q].cls    = dp_cls;
      entries_d[tail_q].dt     = '0;
      entries_d[tail_q].pd     = iDP_pd;
      entries_d[tail_q].jump   = 1'b0;
      entries_d[tail_q].target = '0;
      entries_d[tail_q].pc     = iDP_pc;
    end
    if (flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_d[i].busy = 1'b0;
      end
    end
  end

  // Pointer and occupancy next-state; a flush empties the queue outright.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (commit) head_d = head_q + IDX_W'(1);
    if (alloc)  tail_d = tail_q + IDX_W'(1);
    if (alloc && !commit)      count_d = count_q + CNT_W'(1);
    else if (!alloc && commit) count_d = count_q - CNT_W'(1);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Commit outputs: pulses default low, data fields hold until the next commit.
  always_comb begin
    rf_en_d    = 1'b0;
    lsb_en_d   = 1'b0;
    clr_d      = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_dt_d    = rf_dt_q;
    rf_nick_d  = rf_nick_q;
    lsb_nick_d = lsb_nick_q;
    if_pc_d    = if_pc_q;
    if (commit) begin
      case (head_e.cls)
        CLS_ALU, CLS_JALR: begin
          rf_en_d   = 1'b1;
          rf_rd_d   = head_e.rd;
          rf_dt_d   = head_e.dt;
          rf_nick_d = nick_of(head_q);
        end
        CLS_STORE: begin
          lsb_en_d   = 1'b1;
          lsb_nick_d = nick_of(head_q);
        end
        default: ;
      endcase
    end
    if (flush) begin
      clr_d   = 1'b1;
      if_pc_d = head_e.jump ? head_e.target : (head_e.pc + 32'd4);
    end
  end

  // Entry storage; with rdy low every _d above equals its _q, so state holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

  // Pointers and registered commit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_en_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_dt_q    <= '0;
      rf_nick_q  <= '0;
      lsb_en_q   <= 1'b0;
      lsb_nick_q <= '0;
      clr_q      <= 1'b0;
      if_pc_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_en_q    <= rf_en_d;
      rf_rd_q    <= rf_rd_d;
      rf_dt_q    <= rf_dt_d;
      rf_nick_q  <= rf_nick_d;
      lsb_en_q   <= lsb_en_d;
      lsb_nick_q <= lsb_nick_d;
      clr_q      <= clr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign oRF_en           = rf_en_q;
  assign oRF_rd_regnm     = rf_rd_q;
  assign oRF_rd_dt        = rf_dt_q;
  assign oRF_rd_nick      = rf_nick_q;
  assign oLSB_commit_en   = lsb_en_q;
  assign oLSB_commit_nick = lsb_nick_q;
  assign oclr             = clr_q;
  assign oIF_pc           = if_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation/rename, full and wrap,
// in-order retirement of out-of-order results, mispredict flush, operand
// forwarding, store release, rdy freeze.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        iDP_en;
  logic [4:0]  iDP_rd_regnm;
  logic [5:0]  iDP_op;
  logic [31:0] iDP_pc;
  logic        iDP_pd;
  logic [4:0]  oDP_nick;
  logic        oDP_full;
  logic [4:0]  iDP_rs1_nick, iDP_rs2_nick;
  logic        oDP_rs1_rdy, oDP_rs2_rdy;
  logic [31:0] oDP_rs1_dt, oDP_rs2_dt;
  logic        oRF_nick_en;
  logic [4:0]  oRF_nick_regnm;
  logic [4:0]  oRF_nick;
  logic        iALU_en;
  logic [4:0]  iALU_nick;
  logic [31:0] iALU_dt;
  logic        iALU_jump;
  logic [31:0] iALU_target;
  logic        iLSB_en;
  logic [4:0]  iLSB_nick;
  logic [31:0] iLSB_dt;
  logic        oRF_en;
  logic [4:0]  oRF_rd_regnm;
  logic [31:0] oRF_rd_dt;
  logic [4:0]  oRF_rd_nick;
  logic        oLSB_commit_en;
  logic [4:0]  oLSB_commit_nick;
  logic        oclr;
  logic [31:0] oIF_pc;

  reorder_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .iDP_en           (iDP_en),
    .iDP_rd_regnm     (iDP_rd_regnm),
    .iDP_op           (iDP_op),
    .iDP_pc           (iDP_pc),
    .iDP_pd           (iDP_pd),
    .oDP_nick         (oDP_nick),
    .oDP_full         (oDP_full),
    .iDP_rs1_nick     (iDP_rs1_nick),
    .iDP_rs2_nick     (iDP_rs2_nick),
    .oDP_rs1_rdy      (oDP_rs1_rdy),
    .oDP_rs2_rdy      (oDP_rs2_rdy),
    .oDP_rs1_dt       (oDP_rs1_dt),
    .oDP_rs2_dt       (oDP_rs2_dt),
    .oRF_nick_en      (oRF_nick_en),
    .oRF_nick_regnm   (oRF_nick_regnm),
    .oRF_nick         (oRF_nick),
    .iALU_en          (iALU_en),
    .iALU_nick        (iALU_nick),
    .iALU_dt          (iALU_dt),
    .iALU_jump        (iALU_jump),
    .iALU_target      (iALU_target),
    .iLSB_en          (iLSB_en),
    .iLSB_nick        (iLSB_nick),
    .iLSB_dt          (iLSB_dt),
    .oRF_en           (oRF_en),
    .oRF_rd_regnm     (oRF_rd_regnm),
    .oRF_rd_dt        (oRF_rd_dt),
    .oRF_rd_nick      (oRF_rd_nick),
    .oLSB_commit_en   (oLSB_commit_en),
    .oLSB_commit_nick (oLSB_commit_nick),
    .oclr             (oclr),
    .oIF_pc           (oIF_pc)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iDP_en = 0; iDP_rd_regnm = 0; iDP_op = OP_NOP; iDP_pc = 0; iDP_pd = 0;
    iDP_rs1_nick = 0; iDP_rs2_nick = 0;
    iALU_en = 0; iALU_nick = 0; iALU_dt = 0; iALU_jump = 0; iALU_target = 0;
    iLSB_en = 0; iLSB_nick = 0; iLSB_dt = 0;
    rdy = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic drive_alloc(input logic [5:0] op, input logic [4:0] rd,
                             input logic [31:0] pc, input logic pd);
    iDP_en = 1; iDP_op = op; iDP_rd_regnm = rd; iDP_pc = pc; iDP_pd = pd;
  endtask

  task automatic drive_alu(input logic [4:0] nick, input logic [31:0] dt,
                           input logic jump, input logic [31:0] target);
    iALU_en = 1; iALU_nick = nick; iALU_dt = dt; iALU_jump = jump; iALU_target = target;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    $display("FAIL watchdog: time budget exceeded, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic rf_seen, clr_seen;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1;
    idle_inputs();

    // Reset state, then ADDI rd=5 through rename, writeback and commit.
    do_reset();
    check_eq("rst_rf_en",   32'(oRF_en), 32'd0);
    check_eq("rst_lsb_en",  32'(oLSB_commit_en), 32'd0);
    check_eq("rst_clr",     32'(oclr), 32'd0);
    check_eq("rst_if_pc",   oIF_pc, 32'd0);
    check_eq("rst_rf_dt",   oRF_rd_dt, 32'd0);
    check_eq("rst_full",    32'(oDP_full), 32'd0);
    check_eq("rst_nick",    32'(oDP_nick), 32'd1);
    drive_alloc(OP_ADDI, 5'd5, 32'h1000, 1'b0);
    #1;
    check_eq("addi_nick",     32'(oDP_nick), 32'd1);
    check_eq("addi_nick_en",  32'(oRF_nick_en), 32'd1);
    check_eq("addi_regnm",    32'(oRF_nick_regnm), 32'd5);
    check_eq("addi_rf_nick",  32'(oRF_nick), 32'd1);
    tick();
    iDP_en = 0;
    drive_alu(5'd1, 32'h10, 1'b0, 32'h0);
    #1;
    check_eq("addi_next_nick", 32'(oDP_nick), 32'd2);
    tick();
    iALU_en = 0;
    check_eq("addi_wb_no_commit", 32'(oRF_en), 32'd0);
    tick();
    check_eq("addi_rf_en",   32'(oRF_en), 32'd1);
    check_eq("addi_rf_rd",   32'(oRF_rd_regnm), 32'd5);
    check_eq("addi_rf_dt",   oRF_rd_dt, 32'h10);
    check_eq("addi_rf_nick_c", 32'(oRF_rd_nick), 32'd1);
    check_eq("addi_no_clr",  32'(oclr), 32'd0);
    tick();
    check_eq("addi_rf_pulse", 32'(oRF_en), 32'd0);

    // Fill all 16 entries; the 17th request must be refused.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_alloc(OP_ADDI, 5'(i + 1), 32'h2000 + 32'(4 * i), 1'b0);
      tick();
    end
    drive_alloc(OP_ADDI, 5'd31, 32'h3000, 1'b0);
    #1;
    check_eq("full_set",      32'(oDP_full), 32'd1);
    check_eq("full_nick_en",  32'(oRF_nick_en), 32'd0);
    check_eq("full_wrap_nick", 32'(oDP_nick), 32'd1);
    tick();
    iDP_en = 0;
    check_eq("full_hold", 32'(oDP_full), 32'd1);
    drive_alu(5'd1, 32'h55, 1'b0, 32'h0);
    tick();
    iALU_en = 0;
    check_eq("full_before_commit", 32'(oDP_full), 32'd1);
    tick();
    check_eq("full_commit_en", 32'(oRF_en), 32'd1);
    check_eq("full_commit_rd", 32'(oRF_rd_regnm), 32'd1);
    check_eq("full_commit_dt", oRF_rd_dt, 32'h55);
    check_eq("full_dropped",   32'(oDP_full), 32'd0);
    check_eq("full_next_nick", 32'(oDP_nick), 32'd1);

    // Results arrive 3,2,1; retirement must still be 1,2,3 back to back.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive_alloc(OP_ADDI, 5'(i), 32'h4000 + 32'(4 * i), 1'b0);
      tick();
    end
    iDP_en = 0;
    for (int i = 3; i >= 1; i--) begin
      drive_alu(5'(i), 32'(i * 16'h11), 1'b0, 32'h0);
      exp_q.push_front({8'(i), 8'(i), 16'(i * 16'h11)});
      tick();
    end
    iALU_en = 0;
    check_eq("ooo_no_early_commit", 32'(oRF_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("ooo_commit_en", 32'(oRF_en), 32'd1);
      check_eq("ooo_commit", {3'b0, oRF_rd_nick, 3'b0, oRF_rd_regnm, oRF_rd_dt[15:0]},
               exp_q.pop_front());
    end
    tick();
    check_eq("ooo_done", 32'(oRF_en), 32'd0);

    // BEQ predicted not-taken resolves taken: flush, younger ADDI is dropped.
    do_reset();
    drive_alloc(OP_BEQ, 5'd0, 32'h200, 1'b0);
    tick();
    drive_alloc(OP_ADDI, 5'd7, 32'h204, 1'b0);
    tick();
    iDP_en = 0;
    drive_alu(5'd1, 32'h0, 1'b1, 32'h100);
    iLSB_en = 1; iLSB_nick = 5'd2; iLSB_dt = 32'h1;
    tick();
    idle_inputs();
    check_eq("br_no_clr_yet", 32'(oclr), 32'd0);
    tick();
    check_eq("br_clr",        32'(oclr), 32'd1);
    check_eq("br_if_pc",      oIF_pc, 32'h100);
    check_eq("br_no_rf",      32'(oRF_en), 32'd0);
    check_eq("br_tail_reset", 32'(oDP_nick), 32'd1);
    drive_alloc(OP_ADDI, 5'd9, 32'h300, 1'b0);
    #1;
    check_eq("br_alloc_blocked", 32'(oRF_nick_en), 32'd0);
    tick();
    iDP_en = 0;
    check_eq("br_clr_one_cycle", 32'(oclr), 32'd0);
    check_eq("br_no_alloc",      32'(oDP_nick), 32'd1);
    rf_seen  = 0;
    clr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      rf_seen  = rf_seen | oRF_en;
      clr_seen = clr_seen | oclr;
    end
    check_eq("br_younger_dropped", 32'(rf_seen), 32'd0);
    check_eq("br_no_reflush",      32'(clr_seen), 32'd0);

    // Operand lookup: bus forwarding, stored value, tag 0, ALU over stored.
    do_reset();
    drive_alloc(OP_ADDI, 5'd3, 32'h500, 1'b0);
    tick();
    drive_alloc(OP_ADDI, 5'd4, 32'h504, 1'b0);
    tick();
    iDP_en = 0;
    iLSB_en = 1; iLSB_nick = 5'd2; iLSB_dt = 32'hAB;
    iDP_rs1_nick = 5'd2;
    iDP_rs2_nick = 5'd1;
    #1;
    check_eq("lk_fwd_rdy",    32'(oDP_rs1_rdy), 32'd1);
    check_eq("lk_fwd_dt",     oDP_rs1_dt, 32'hAB);
    check_eq("lk_pending",    32'(oDP_rs2_rdy), 32'd0);
    tick();
    iLSB_en = 0;
    #1;
    check_eq("lk_stored_rdy", 32'(oDP_rs1_rdy), 32'd1);
    check_eq("lk_stored_dt",  oDP_rs1_dt, 32'hAB);
    iDP_rs1_nick = 5'd0;
    drive_alu(5'd2, 32'hCD, 1'b0, 32'h0);
    iDP_rs2_nick = 5'd2;
    #1;
    check_eq("lk_tag0",       32'(oDP_rs1_rdy), 32'd0);
    check_eq("lk_alu_prio",   oDP_rs2_dt, 32'hCD);
    tick();
    idle_inputs();

    // Store: ready at allocation, released to the LSB one cycle later.
    do_reset();
    drive_alloc(OP_SW, 5'd0, 32'h600, 1'b0);
    #1;
    check_eq("sw_no_rename", 32'(oRF_nick_en), 32'd0);
    tick();
    iDP_en = 0;
    check_eq("sw_not_yet",   32'(oLSB_commit_en), 32'd0);
    tick();
    check_eq("sw_commit_en", 32'(oLSB_commit_en), 32'd1);
    check_eq("sw_commit_nk", 32'(oLSB_commit_nick), 32'd1);
    check_eq("sw_no_rf",     32'(oRF_en), 32'd0);
    tick();
    check_eq("sw_pulse",     32'(oLSB_commit_en), 32'd0);

    // rdy low freezes allocation and commit.
    do_reset();
    rdy = 0;
    drive_alloc(OP_SW, 5'd0, 32'h700, 1'b0);
    tick();
    tick();
    check_eq("rdy_no_alloc", 32'(oDP_nick), 32'd1);
    rdy = 1;
    tick();
    iDP_en = 0;
    rdy = 0;
    tick();
    check_eq("rdy_no_commit", 32'(oLSB_commit_en), 32'd0);
    rdy = 1;
    tick();
    check_eq("rdy_commit",    32'(oLSB_commit_en), 32'd1);

    // JALR always redirects and still writes rd.
    do_reset();
    drive_alloc(OP_JALR, 5'd1, 32'h40, 1'b0);
    #1;
    check_eq("jalr_rename", 32'(oRF_nick_en), 32'd1);
    tick();
    iDP_en = 0;
    drive_alu(5'd1, 32'h44, 1'b1, 32'h80);
    tick();
    iALU_en = 0;
    tick();
    check_eq("jalr_rf_en", 32'(oRF_en), 32'd1);
    check_eq("jalr_rf_dt", oRF_rd_dt, 32'h44);
    check_eq("jalr_clr",   32'(oclr), 32'd1);
    check_eq("jalr_pc",    oIF_pc, 32'h80);

    // BNE predicted taken resolves not-taken: redirect to pc+4.
    do_reset();
    drive_alloc(OP_BNE, 5'd0, 32'h500, 1'b1);
    tick();
    iDP_en = 0;
    drive_alu(5'd1, 32'h0, 1'b0, 32'h999);
    tick();
    iALU_en = 0;
    tick();
    check_eq("bne_clr", 32'(oclr), 32'd1);
    check_eq("bne_pc",  oIF_pc, 32'h504);

    // Correctly predicted taken branch retires quietly.
    do_reset();
    drive_alloc(OP_BEQ, 5'd0, 32'h800, 1'b1);
    tick();
    iDP_en = 0;
    drive_alu(5'd1, 32'h0, 1'b1, 32'h900);
    tick();
    iALU_en = 0;
    tick();
    check_eq("beq_ok_no_clr", 32'(oclr), 32'd0);
    check_eq("beq_ok_no_rf",  32'(oRF_en), 32'd0);
    check_eq("beq_ok_nick",   32'(oDP_nick), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
